// File: rtl/spi_shift_reg_8bits_if.sv
// Bus bundle for the SPI data-path shift register: load/shift/unload controls
// plus serial and parallel data. The master modport is the external controller.
interface spi_shift_reg_8bits_if;
  logic [7:0] data;
  logic       Ld;
  logic       in;
  logic       en;
  logic       out;
  logic [7:0] data_out;
  logic       un_ld;

  modport master (
    output data,
    output Ld,
    output in,
    output en,
    output un_ld,
    input  out,
    input  data_out
  );

  modport slave (
    input  data,
    input  Ld,
    input  in,
    input  en,
    input  un_ld,
    output out,
    output data_out
  );
endinterface

// File: rtl/spi_shift_reg_8bits.sv
// Eight-bit SISO/PISO/SIPO shift register forming an SPI data path.
// Define SHIFT_REG_LSB_FIRST_EN to shift LSB first instead of the default MSB first.
module spi_shift_reg_8bits (
  input  logic                    clk,
  input  logic                    rst,
  spi_shift_reg_8bits_if.slave    bus
);
  localparam int WIDTH = 8;

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] data_out_q;
  logic [WIDTH-1:0] data_out_d;

  // Load takes priority over shift; otherwise the register holds.
  always_comb begin
    sr_d = sr_q;
    if (bus.Ld) begin
      sr_d = bus.data;
    end else if (bus.en) begin
`ifdef SHIFT_REG_LSB_FIRST_EN
      sr_d = {bus.in, sr_q[WIDTH-1:1]};
`else
      sr_d = {sr_q[WIDTH-2:0], bus.in};
`endif
    end
  end

  // Unload captures the pre-edge register, so a same-cycle shift is not seen.
  always_comb begin
    data_out_d = data_out_q;
    if (bus.un_ld) begin
      data_out_d = sr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q       <= '0;
      data_out_q <= '0;
    end else begin
      sr_q       <= sr_d;
      data_out_q <= data_out_d;
    end
  end

`ifdef SHIFT_REG_LSB_FIRST_EN
  assign bus.out = sr_q[0];
`else
  assign bus.out = sr_q[WIDTH-1];
`endif
  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_spi_shift_reg_8bits.sv
// Self-checking bench: two instances (optionally chained as an SPI ring) compared
// against a byte-level arithmetic model, with directed and random phases.
module tb_spi_shift_reg_8bits;
  logic clk;
  logic rst;
  logic ring_mode;
  logic in_a_drv;
  logic in_b_drv;

  int checks;
  int errors;

  logic [7:0] m_sr_a;
  logic [7:0] m_sr_b;
  logic [7:0] m_do_a;
  logic [7:0] m_do_b;

  spi_shift_reg_8bits_if if_a ();
  spi_shift_reg_8bits_if if_b ();

  assign if_a.in = ring_mode ? if_b.out : in_a_drv;
  assign if_b.in = ring_mode ? if_a.out : in_b_drv;

  spi_shift_reg_8bits dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  spi_shift_reg_8bits dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial output bit the protocol exposes for a given register value.
  function automatic logic model_out(input logic [7:0] v);
`ifdef SHIFT_REG_LSB_FIRST_EN
    return v[0];
`else
    return v[7];
`endif
  endfunction

  function automatic logic [7:0] model_next(input logic [7:0] cur, input logic r,
                                            input logic ld, input logic [7:0] d,
                                            input logic e, input logic si);
    int v;
    if (r) return 8'h00;
    if (ld) return d;
    if (!e) return cur;
`ifdef SHIFT_REG_LSB_FIRST_EN
    v = (int'(cur) / 2) + (si ? 128 : 0);
`else
    v = ((int'(cur) * 2) % 256) + (si ? 1 : 0);
`endif
    return v[7:0];
  endfunction

  // Advance the model with the currently driven inputs, then clock the DUTs.
  task automatic applyStimulus();
    logic       sin_a;
    logic       sin_b;
    logic [7:0] n_sr_a;
    logic [7:0] n_sr_b;
    logic [7:0] n_do_a;
    logic [7:0] n_do_b;
    sin_a  = ring_mode ? model_out(m_sr_b) : in_a_drv;
    sin_b  = ring_mode ? model_out(m_sr_a) : in_b_drv;
    n_sr_a = model_next(m_sr_a, rst, if_a.Ld, if_a.data, if_a.en, sin_a);
    n_sr_b = model_next(m_sr_b, rst, if_b.Ld, if_b.data, if_b.en, sin_b);
    n_do_a = rst ? 8'h00 : (if_a.un_ld ? m_sr_a : m_do_a);
    n_do_b = rst ? 8'h00 : (if_b.un_ld ? m_sr_b : m_do_b);
    @(posedge clk);
    #1;
    m_sr_a = n_sr_a;
    m_sr_b = n_sr_b;
    m_do_a = n_do_a;
    m_do_b = n_do_b;
  endtask

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, " a.out"}, {7'b0, if_a.out}, {7'b0, model_out(m_sr_a)});
    checkVal({tag, " b.out"}, {7'b0, if_b.out}, {7'b0, model_out(m_sr_b)});
    checkVal({tag, " a.data_out"}, if_a.data_out, m_do_a);
    checkVal({tag, " b.data_out"}, if_b.data_out, m_do_b);
  endtask

  task automatic idleInputs();
    if_a.Ld = 1'b0; if_a.en = 1'b0; if_a.un_ld = 1'b0; if_a.data = 8'h00;
    if_b.Ld = 1'b0; if_b.en = 1'b0; if_b.un_ld = 1'b0; if_b.data = 8'h00;
    in_a_drv = 1'b0; in_b_drv = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    ring_mode = 1'b0;
    rst       = 1'b1;
    m_sr_a = 8'h00; m_sr_b = 8'h00; m_do_a = 8'h00; m_do_b = 8'h00;
    idleInputs();
    #2;

    // Reset overrides a simultaneous load.
    if_a.Ld = 1'b1; if_a.data = 8'hAA;
    if_b.Ld = 1'b1; if_b.data = 8'hAA;
    applyStimulus();
    applyStimulus();
    checkOutput("reset");
    checkVal("reset a.out const", {7'b0, if_a.out}, 8'h00);
    rst = 1'b0;
    idleInputs();

    // Load 8E, then hold for three edges, then unload.
    if_a.Ld = 1'b1; if_a.data = 8'h8E;
    applyStimulus();
    checkOutput("load");
    idleInputs();
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput($sformatf("hold%0d", i));
    end
    if_a.un_ld = 1'b1;
    applyStimulus();
    checkVal("hold unload", if_a.data_out, 8'h8E);
    idleInputs();

    // Eight shifts with in=0 drain the byte.
    if_a.Ld = 1'b1; if_a.data = 8'h8E;
    applyStimulus();
    idleInputs();
    if_a.en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus();
      checkOutput($sformatf("shift%0d", i));
    end
    if_a.en = 1'b0; if_a.un_ld = 1'b1;
    applyStimulus();
    checkVal("shift drained", if_a.data_out, 8'h00);
    idleInputs();

    // Ring exchange between the two instances.
    ring_mode = 1'b1;
    if_a.Ld = 1'b1; if_a.data = 8'h8E;
    if_b.Ld = 1'b1; if_b.data = 8'hFF;
    applyStimulus();
    idleInputs();
    if_a.en = 1'b1; if_b.en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus();
      checkOutput($sformatf("ring%0d", i));
    end
    idleInputs();
    if_a.un_ld = 1'b1; if_b.un_ld = 1'b1;
    applyStimulus();
    checkVal("ring a", if_a.data_out, 8'hFF);
    checkVal("ring b", if_b.data_out, 8'h8E);
    ring_mode = 1'b0;
    idleInputs();

    // Load beats shift; unload during a shift sees the pre-shift value.
    if_a.Ld = 1'b1; if_a.en = 1'b1; if_a.data = 8'h3C; in_a_drv = 1'b1;
    applyStimulus();
    idleInputs();
    if_a.en = 1'b1; if_a.un_ld = 1'b1; in_a_drv = 1'b1;
    applyStimulus();
    checkVal("prio load", if_a.data_out, 8'h3C);
    checkOutput("prio shift");
    if_a.en = 1'b0;
    applyStimulus();
`ifdef SHIFT_REG_LSB_FIRST_EN
    checkVal("prio after", if_a.data_out, 8'h9E);
`else
    checkVal("prio after", if_a.data_out, 8'h79);
`endif
    idleInputs();

    // Reset mid-transfer, then shifting resumes from zero.
    if_a.Ld = 1'b1; if_a.data = 8'hC3;
    applyStimulus();
    idleInputs();
    if_a.en = 1'b1; in_a_drv = 1'b1; if_a.un_ld = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus();
    checkOutput("pre-reset");
    rst = 1'b1;
    applyStimulus();
    checkOutput("mid reset");
    checkVal("mid reset a.data_out", if_a.data_out, 8'h00);
    rst = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("resume");
`ifdef SHIFT_REG_LSB_FIRST_EN
    checkVal("resume value", if_a.data_out, 8'h80);
`else
    checkVal("resume value", if_a.data_out, 8'h01);
`endif
    idleInputs();

    // Random controls, occasional reset, random ring chaining.
    for (int i = 0; i < 300; i++) begin
      rst        = ($urandom_range(0, 31) == 0);
      ring_mode  = ($urandom_range(0, 3) == 0);
      if_a.Ld    = ($urandom_range(0, 5) == 0);
      if_b.Ld    = ($urandom_range(0, 5) == 0);
      if_a.en    = $urandom_range(0, 1) != 0;
      if_b.en    = $urandom_range(0, 1) != 0;
      if_a.un_ld = $urandom_range(0, 1) != 0;
      if_b.un_ld = $urandom_range(0, 1) != 0;
      if_a.data  = 8'($urandom);
      if_b.data  = 8'($urandom);
      in_a_drv   = $urandom_range(0, 1) != 0;
      in_b_drv   = $urandom_range(0, 1) != 0;
      applyStimulus();
      checkOutput($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
